// File: rtl/gcd_pkg.sv
// Shared types and helpers for the binary-GCD engine family.
package gcd_pkg;

   typedef enum logic [1:0] {
      GCD_IDLE = 2'd0,
      GCD_CALC = 2'd1,
      GCD_DONE = 2'd2
   } gcd_state_e;

   localparam logic [1:0] ST_IDLE = GCD_IDLE;
   localparam logic [1:0] ST_CALC = GCD_CALC;
   localparam logic [1:0] ST_DONE = GCD_DONE;

   // Operands are extended to MAXW bits before conditioning so that the
   // most-negative value negates without overflow.
   localparam int MAXW = 128;

   function automatic int cycles_bound(input int w);
      return 2 * w + 1;
   endfunction

   function automatic logic [MAXW-1:0] abs_w(input logic [MAXW-1:0] v,
                                             input logic            signed_in);
      if (signed_in && v[MAXW-1]) abs_w = '0 - v;
      else                        abs_w = v;
   endfunction

endpackage

// File: rtl/gcd_stein_step.sv
// One combinational iteration of the binary GCD reduction.
module gcd_stein_step #(
   parameter int WIDTH = 16,
   parameter int KW    = 5
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [KW-1:0]    k_i,
   output logic [WIDTH-1:0] a_o,
   output logic [WIDTH-1:0] b_o,
   output logic [KW-1:0]    k_o,
   output logic             term_o
);

   always_comb begin
      a_o    = a_i;
      b_o    = b_i;
      k_o    = k_i;
      term_o = 1'b0;
      if (a_i == '0 || b_i == '0) begin
         term_o = 1'b1;
      end else if (!a_i[0] && !b_i[0]) begin
         a_o = a_i >> 1;
         b_o = b_i >> 1;
         k_o = k_i + 1'b1;
      end else if (!a_i[0]) begin
         a_o = a_i >> 1;
      end else if (!b_i[0]) begin
         b_o = b_i >> 1;
      end else if (a_i >= b_i) begin
         // Difference of two odds is even, so the halving is exact.
         a_o = (a_i - b_i) >> 1;
      end else begin
         b_o = (b_i - a_i) >> 1;
      end
   end

endmodule

// File: rtl/gcd_stein_seq.sv
// Multi-cycle binary (Stein) GCD engine, one reduction step per clock.
// Handshake: a transfer happens on a rising edge where valid and ready are both high.
module gcd_stein_seq
   import gcd_pkg::*;
#(
   parameter int  WIDTH     = 16,
   parameter int  SIGNED_IN = 1,
   localparam int CW        = $clog2(cycles_bound(WIDTH) + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] gcd_o,
   output logic             zero_o,
   output logic [CW-1:0]    cycles_o,
   output logic [1:0]       state_o
);

   localparam int KW = $clog2(WIDTH + 1);

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [KW-1:0]    k_q, k_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] gcd_q, gcd_d;
   logic             zero_q, zero_d;
   logic [CW-1:0]    cycles_q, cycles_d;

   logic [MAXW-1:0]  a_ext, b_ext;
   logic [WIDTH-1:0] a_abs, b_abs;
   logic [WIDTH-1:0] step_a, step_b;
   logic [KW-1:0]    step_k;
   logic             step_term;

   if (SIGNED_IN != 0) begin : g_sext
      assign a_ext = MAXW'($signed(a_i));
      assign b_ext = MAXW'($signed(b_i));
   end else begin : g_zext
      assign a_ext = MAXW'(a_i);
      assign b_ext = MAXW'(b_i);
   end

   assign a_abs = WIDTH'(abs_w(a_ext, SIGNED_IN != 0));
   assign b_abs = WIDTH'(abs_w(b_ext, SIGNED_IN != 0));

   gcd_stein_step #(
      .WIDTH (WIDTH),
      .KW    (KW)
   ) u_step (
      .a_i    (a_q),
      .b_i    (b_q),
      .k_i    (k_q),
      .a_o    (step_a),
      .b_o    (step_b),
      .k_o    (step_k),
      .term_o (step_term)
   );

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      k_d      = k_q;
      cnt_d    = cnt_q;
      gcd_d    = gcd_q;
      zero_d   = zero_q;
      cycles_d = cycles_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               a_d     = a_abs;
               b_d     = b_abs;
               k_d     = '0;
               cnt_d   = '0;
               state_d = ST_CALC;
            end
         end
         ST_CALC: begin
            cnt_d = cnt_q + 1'b1;
            a_d   = step_a;
            b_d   = step_b;
            k_d   = step_k;
            if (step_term) begin
               gcd_d    = (a_q | b_q) << k_q;
               zero_d   = (a_q | b_q) == '0;
               cycles_d = cnt_q + 1'b1;
               state_d  = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         k_q      <= '0;
         cnt_q    <= '0;
         gcd_q    <= '0;
         zero_q   <= 1'b0;
         cycles_q <= '0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         k_q      <= k_d;
         cnt_q    <= cnt_d;
         gcd_q    <= gcd_d;
         zero_q   <= zero_d;
         cycles_q <= cycles_d;
      end
   end

   // Ready is held low for the reset cycle itself, not only afterwards.
   assign in_ready  = (state_q == ST_IDLE) && !rst;
   assign out_valid = (state_q == ST_DONE);
   assign gcd_o     = gcd_q;
   assign zero_o    = zero_q;
   assign cycles_o  = cycles_q;
   assign state_o   = state_q;

   assert property (@(posedge clk) disable iff (rst)
      (state_q == ST_CALC) |-> (cnt_q < CW'(cycles_bound(WIDTH))));

endmodule
